// File: rtl/tx_word_serialiser_if.sv
// Push-side bus between the data router (master) and tx_word_serialiser (slave).
// The router drives a word plus strobe; the serialiser reports FIFO full and fill level.
interface tx_word_serialiser_if #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
);
    logic                     i_word_valid;
    logic [31:0]              i_word;
    logic                     o_busy;
    logic [FIFO_DEPTH_LOG2:0] o_fifo_level;

    modport master (
        output i_word_valid,
        output i_word,
        input  o_busy,
        input  o_fifo_level
    );

    modport slave (
        input  i_word_valid,
        input  i_word,
        output o_busy,
        output o_fifo_level
    );
endinterface

// File: rtl/tx_word_serialiser.sv
// tx_word_serialiser: buffers 32-bit router words in a small FIFO and feeds them, MSB
// first, one byte at a time into a byte-wide UART transmitter.
// Optional feature macro: TX_WORD_SERIALISER_OVERFLOW_EN enables the sticky o_overflow
// flag; without it o_overflow is tied low.
module tx_word_serialiser #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 3,
    parameter int unsigned ACK_TIMEOUT     = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    tx_word_serialiser_if.slave  push,
    output logic [7:0]           o_tx_byte,
    output logic                 o_tx_start,
    input  logic                 i_tx_busy,
    output logic                 o_idle,
    output logic                 o_overflow
);
    localparam int unsigned AW    = FIFO_DEPTH_LOG2;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = $clog2(ACK_TIMEOUT + 1) + 1;

    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StAck, StDrain} state_e;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          busy_q;
    logic          idle_q;

    state_e        state_q;
    logic [31:0]   shift_q;
    logic [1:0]    byte_cnt_q;
    logic [CW-1:0] ack_cnt_q;
    logic          tx_start_q;
    logic [7:0]    tx_byte_q;

    logic push_ok;
    logic pop;
    logic fsm_idle_next;

    // Full is judged on the current level, so a push into a full FIFO is lost even
    // when the FSM pops in the same cycle.
    assign push_ok = push.i_word_valid && (level_q != LEVEL_FULL);
    assign pop     = (state_q == StIdle) && (level_q != '0);

    // FSM will be in IDLE after this edge without having popped.
    assign fsm_idle_next = ((state_q == StIdle) && (level_q == '0)) ||
                           ((state_q == StDrain) && !i_tx_busy && (byte_cnt_q == 2'd3));

    // Next FIFO level from accepted push and pop.
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Word storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge i_clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push.i_word;
        end
    end

    // Pointers, level and the registered full/idle status.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            busy_q   <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            busy_q  <= (level_d == LEVEL_FULL);
            idle_q  <= (level_d == '0) && fsm_idle_next;
        end
    end

    // Byte serialiser FSM: pop, issue a start, wait for the UART to ack, wait for it to drain.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            ack_cnt_q  <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (level_q != '0) begin
                        shift_q    <= mem[rd_ptr_q];
                        byte_cnt_q <= '0;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    if (!i_tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= shift_q[31:24];
                        ack_cnt_q  <= '0;
                        state_q    <= StAck;
                    end
                end
                StAck: begin
                    // A UART that never raises busy is assumed to have taken the byte.
                    if (i_tx_busy || (ack_cnt_q == ACK_LAST)) begin
                        state_q <= StDrain;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (!i_tx_busy) begin
                        shift_q    <= {shift_q[23:0], 8'h00};
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        state_q    <= (byte_cnt_q == 2'd3) ? StIdle : StIssue;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef TX_WORD_SERIALISER_OVERFLOW_EN
    logic overflow_q;

    // Sticky record of any push lost to a full FIFO.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            overflow_q <= 1'b0;
        end else if (push.i_word_valid && !push_ok) begin
            overflow_q <= 1'b1;
        end
    end

    assign o_overflow = overflow_q;
`else
    assign o_overflow = 1'b0;
`endif

    assign push.o_busy       = busy_q;
    assign push.o_fifo_level = level_q;
    assign o_tx_byte         = tx_byte_q;
    assign o_tx_start        = tx_start_q;
    assign o_idle            = idle_q;
endmodule
